gen_scheduler: RTL and testbench
================================

Name: gen_scheduler

Overview:
- Sequences the single-generation sweep engine.
- Decides when each generation starts: free-running at a programmable rate, or one generation per user step.
- Counts completed generations.
- Arbitrates the field memory between the simulator and a user cell-edit port, so edits never overlap a sweep.
- Sits between the button/switch debouncers and the sweep engine's go / is_simulating pair.

Parameters:
TICK_CYCLES, 1000000, clk cycles per base tick (prescaler period)
SPEED_W, 3, width of speed select; period = (i_speed+1) base ticks
GEN_W, 16, width of generation counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_run  in  1  single-cycle pulse: enter free-run mode
i_pause  in  1  single-cycle pulse: leave free-run mode
i_step  in  1  single-cycle pulse: run exactly one generation while paused
i_speed  in  SPEED_W  generation period select
i_is_simulating  in  1  sweep engine busy flag
i_edit_req  in  1  level: user edit port requests field access
o_go  out  1  one-cycle start pulse to sweep engine
o_edit_gnt  out  1  edit port owns field memory
o_running  out  1  free-run mode active
o_busy  out  1  generation in flight (LAUNCH or SIM)
o_gen_cnt  out  GEN_W  completed generations, wraps modulo 2^GEN_W

Behaviour:
- Reset (async, rst_n low): state IDLE, run_mode=0, pause_pend=0, prescaler=0, tick_cnt=0, gen_cnt=0. All outputs 0.
- Clock domain: all logic in clk. Reset deassertion mid-sweep is not handled; the sweep engine shares rst_n.
- States: IDLE, WAIT_TICK, LAUNCH, SIM, EDIT.
- IDLE (paused):
  - i_edit_req -> EDIT.
  - Else i_run -> run_mode=1, clear prescaler/tick_cnt -> WAIT_TICK.
  - Else i_step -> LAUNCH.
- WAIT_TICK (running):
  - Prescaler counts 0..TICK_CYCLES-1; on wrap, tick_cnt++.
  - When tick_cnt reaches i_speed+1 (SPEED_W+1 bit compare, sampled at that cycle) -> LAUNCH, counters cleared.
  - i_pause -> run_mode=0 -> IDLE.
  - i_edit_req -> EDIT; prescaler/tick_cnt frozen.
  - Priority: pause > edit > tick expiry.
- LAUNCH: exactly one cycle, o_go=1 -> SIM. The sweep engine registers is_simulating=1 on that edge, so i_is_simulating is 1 on SIM entry.
- SIM: wait while i_is_simulating=1. On the first cycle it is 0:
  - gen_cnt++ (wrap).
  - Go to IDLE if run_mode=0 or pause_pend=1 (clear pause_pend, run_mode=0).
  - Else go to WAIT_TICK with counters cleared.
- EDIT: o_edit_gnt=1. Exit on the first cycle with i_edit_req=0, to WAIT_TICK (counters resume) if run_mode, else IDLE.
- o_busy=1 in LAUNCH and SIM. o_running=run_mode.
- Commands inside LAUNCH/SIM:
  - i_pause sets pause_pend.
  - i_run clears pause_pend and sets run_mode.
  - i_step is ignored.
- Commands inside EDIT:
  - i_pause clears run_mode; i_run sets it.
  - i_step is ignored.
- i_step while running is ignored.
- i_pause and i_run in the same cycle: pause wins.
- i_edit_req during LAUNCH/SIM is not granted until SIM exits. From the resulting IDLE/WAIT_TICK it is granted the next cycle, before any new launch.
- o_go and o_edit_gnt are never both 1, and never 1 while i_is_simulating=1.
- i_speed changes take effect at the next comparison; no glitch handling needed.

Decomposition:
- Shared package: sched_state_t enum (IDLE, WAIT_TICK, LAUNCH, SIM, EDIT).
- Sub-module tick_prescaler (parameter TICK_CYCLES; inputs clr, en; output tick pulse) is natural and reusable for cursor blink.
- All other logic lives in one FSM module with a packed state struct and a comb next-state block, matching the sweep engine's style.

Test Plan:
- Reset then step (TICK_CYCLES=4, sweep model busy 10 cycles): i_step at cycle 5 -> o_go high exactly cycle 6. o_busy 1 until is_simulating drops, then gen_cnt=1, state IDLE, o_go never reasserts.
- Free run, i_speed=2: i_run -> o_go pulses spaced 12 cycles of WAIT_TICK plus sweep time + 2. After 5 launches, gen_cnt=5.
- Pause mid-sweep: i_pause during SIM -> sweep completes, gen_cnt increments once, o_running=0, no further o_go for 200 cycles.
- Edit arbitration: i_edit_req raised during SIM -> o_edit_gnt stays 0 until SIM exit, then 1 next cycle. While held in run mode, no o_go. Release -> tick count resumes and o_go occurs after remaining ticks.
- Simultaneous i_run+i_pause in IDLE -> stays IDLE, o_running=0. i_step while running -> no extra o_go.
- Async reset asserted in WAIT_TICK with gen_cnt=7 -> all outputs 0 immediately without a clock edge, gen_cnt=0. Wrap: force GEN_W=4, 16 steps -> gen_cnt=0.

Source files
------------

// File: rtl/gen_scheduler_pkg.sv
// Shared types for the generation scheduler: FSM state encoding and small decode helpers.
package gen_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    LAUNCH    = 3'd2,
    SIM       = 3'd3,
    EDIT      = 3'd4
  } sched_state_t;

  function automatic logic is_busy_state(input sched_state_t s);
    return (s == LAUNCH) || (s == SIM);
  endfunction

endpackage

// File: rtl/gen_scheduler_if.sv
// Command, sweep-engine and edit-port signals of the generation scheduler.
interface gen_scheduler_if #(
  parameter int SPEED_W = 3,
  parameter int GEN_W   = 16
);
  logic               i_run;
  logic               i_pause;
  logic               i_step;
  logic [SPEED_W-1:0] i_speed;
  logic               i_is_simulating;
  logic               i_edit_req;
  logic               o_go;
  logic               o_edit_gnt;
  logic               o_running;
  logic               o_busy;
  logic [GEN_W-1:0]   o_gen_cnt;

  modport slave (
    input  i_run, i_pause, i_step, i_speed, i_is_simulating, i_edit_req,
    output o_go, o_edit_gnt, o_running, o_busy, o_gen_cnt
  );

  modport master (
    output i_run, i_pause, i_step, i_speed, i_is_simulating, i_edit_req,
    input  o_go, o_edit_gnt, o_running, o_busy, o_gen_cnt
  );
endinterface

// File: rtl/gen_scheduler_tick_prescaler.sv
// Free-running prescaler: counts 0..TICK_CYCLES-1 while enabled and pulses o_tick on the wrap cycle.
module tick_prescaler #(
  parameter int TICK_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);
  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/gen_scheduler.sv
// Generation scheduler: paces sweep-engine launches (free-run or single step), counts
// completed generations and hands the field memory to the edit port between sweeps.
module gen_scheduler #(
  parameter int TICK_CYCLES = 1000000,
  parameter int SPEED_W     = 3,
  parameter int GEN_W       = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  gen_scheduler_if.slave bus
);
  import gen_scheduler_pkg::*;

  typedef struct packed {
    sched_state_t     state;
    logic             run_mode;
    logic             pause_pend;
    logic [SPEED_W:0] tick_cnt;
    logic [GEN_W-1:0] gen_cnt;
  } sched_regs_t;

  sched_regs_t      r_regs;
  sched_regs_t      w_next;
  logic             w_presc_en;
  logic             w_presc_clr;
  logic             w_tick;
  logic             w_expired;
  logic             w_run_cmd;
  logic [SPEED_W:0] w_tick_cnt_inc;
  logic [SPEED_W:0] w_tick_target;

  // Pause beats run when both arrive together.
  assign w_run_cmd = bus.i_run & ~bus.i_pause;

  // Counters only advance in a WAIT_TICK cycle that is not leaving for IDLE or EDIT.
  assign w_presc_en     = (r_regs.state == WAIT_TICK) & ~bus.i_pause & ~bus.i_edit_req;
  assign w_tick_cnt_inc = r_regs.tick_cnt + {{SPEED_W{1'b0}}, w_tick};
  assign w_tick_target  = {1'b0, bus.i_speed} + {{SPEED_W{1'b0}}, 1'b1};
  assign w_expired      = (w_tick_cnt_inc == w_tick_target);

  tick_prescaler #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_presc_clr),
    .i_en   (w_presc_en),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
    end else begin
      r_regs <= w_next;
    end
  end

  always_comb begin
    w_next      = r_regs;
    w_presc_clr = 1'b0;
    case (r_regs.state)
      IDLE: begin
        if (bus.i_edit_req) begin
          w_next.state = EDIT;
        end else if (w_run_cmd) begin
          w_next.run_mode = 1'b1;
          w_next.tick_cnt = '0;
          w_presc_clr     = 1'b1;
          w_next.state    = WAIT_TICK;
        end else if (bus.i_step) begin
          w_next.state = LAUNCH;
        end
      end
      WAIT_TICK: begin
        if (bus.i_pause) begin
          w_next.run_mode = 1'b0;
          w_next.state    = IDLE;
        end else if (bus.i_edit_req) begin
          w_next.state = EDIT;
        end else if (w_expired) begin
          w_next.tick_cnt = '0;
          w_presc_clr     = 1'b1;
          w_next.state    = LAUNCH;
        end else begin
          w_next.tick_cnt = w_tick_cnt_inc;
        end
      end
      LAUNCH, SIM: begin
        if (bus.i_pause) begin
          w_next.pause_pend = 1'b1;
        end else if (bus.i_run) begin
          w_next.pause_pend = 1'b0;
          w_next.run_mode   = 1'b1;
        end
        if (r_regs.state == LAUNCH) begin
          w_next.state = SIM;
        end else if (!bus.i_is_simulating) begin
          w_next.gen_cnt = r_regs.gen_cnt + GEN_W'(1);
          // A pause seen anywhere in the sweep stops free-run once the generation lands.
          if (!w_next.run_mode || w_next.pause_pend) begin
            w_next.run_mode   = 1'b0;
            w_next.pause_pend = 1'b0;
            w_next.state      = IDLE;
          end else begin
            w_next.tick_cnt = '0;
            w_presc_clr     = 1'b1;
            w_next.state    = WAIT_TICK;
          end
        end
      end
      EDIT: begin
        if (bus.i_pause) begin
          w_next.run_mode = 1'b0;
        end else if (bus.i_run) begin
          w_next.run_mode = 1'b1;
        end
        if (!bus.i_edit_req) begin
          w_next.state = w_next.run_mode ? WAIT_TICK : IDLE;
        end
      end
      default: begin
        w_next.state = IDLE;
      end
    endcase
  end

  assign bus.o_go       = (r_regs.state == LAUNCH);
  assign bus.o_edit_gnt = (r_regs.state == EDIT);
  assign bus.o_busy     = is_busy_state(r_regs.state);
  assign bus.o_running  = r_regs.run_mode;
  assign bus.o_gen_cnt  = r_regs.gen_cnt;

endmodule

// File: tb/tb_gen_scheduler.sv
// Directed bench for gen_scheduler with a cycle-level behavioural model and a 10-cycle sweep engine.
module tb_gen_scheduler;
  localparam int TICK    = 4;
  localparam int SWEEP   = 10;
  localparam int SPEED_W = 3;
  localparam int GEN_W   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gen_scheduler_if #(.SPEED_W(SPEED_W), .GEN_W(GEN_W)) bus ();
  gen_scheduler_if #(.SPEED_W(SPEED_W), .GEN_W(4))     bus4 ();

  gen_scheduler #(.TICK_CYCLES(TICK), .SPEED_W(SPEED_W), .GEN_W(GEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  gen_scheduler #(.TICK_CYCLES(TICK), .SPEED_W(SPEED_W), .GEN_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  assign bus4.i_run           = bus.i_run;
  assign bus4.i_pause         = bus.i_pause;
  assign bus4.i_step          = bus.i_step;
  assign bus4.i_speed         = bus.i_speed;
  assign bus4.i_edit_req      = bus.i_edit_req;
  assign bus4.i_is_simulating = bus.i_is_simulating;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Sweep engine stand-in: busy for SWEEP cycles after each go.
  int sweep_left;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.i_is_simulating <= 1'b0;
      sweep_left          <= 0;
    end else if (bus.o_go) begin
      bus.i_is_simulating <= 1'b1;
      sweep_left          <= SWEEP - 1;
    end else if (sweep_left != 0) begin
      sweep_left <= sweep_left - 1;
    end else begin
      bus.i_is_simulating <= 1'b0;
    end
  end

  // Model: m_fl = 0 no generation, 1 launch cycle, 2 sweeping; m_wait = cycles waited this period.
  int m_fl, m_wait, m_gen;
  bit m_run, m_edit, m_pend;
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_fl = 0; m_wait = 0; m_gen = 0; m_run = 0; m_edit = 0; m_pend = 0;
      end else if (m_fl != 0) begin
        if (bus.i_pause) m_pend = 1;
        else if (bus.i_run) begin m_pend = 0; m_run = 1; end
        if (m_fl == 1) begin
          m_fl = 2;
        end else if (!bus.i_is_simulating) begin
          m_gen = (m_gen + 1) % 65536;
          if (!m_run || m_pend) begin m_run = 0; m_pend = 0; end
          m_fl = 0;
          m_wait = 0;
        end
      end else if (m_edit) begin
        if (bus.i_pause) m_run = 0;
        else if (bus.i_run) m_run = 1;
        if (!bus.i_edit_req) m_edit = 0;
      end else if (m_run) begin
        if (bus.i_pause) m_run = 0;
        else if (bus.i_edit_req) m_edit = 1;
        else begin
          m_wait++;
          if (m_wait == (int'(bus.i_speed) + 1) * TICK) begin m_fl = 1; m_wait = 0; end
        end
      end else begin
        if (bus.i_edit_req) m_edit = 1;
        else if (bus.i_run && !bus.i_pause) begin m_run = 1; m_wait = 0; end
        else if (bus.i_step) m_fl = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_go",      int'(bus.o_go),       int'(m_fl == 1));
      chk("cyc_busy",    int'(bus.o_busy),     int'(m_fl != 0));
      chk("cyc_gnt",     int'(bus.o_edit_gnt), int'(m_edit));
      chk("cyc_running", int'(bus.o_running),  int'(m_run));
      chk("cyc_gen",     int'(bus.o_gen_cnt),  m_gen);
      chk("cyc_gen4",    int'(bus4.o_gen_cnt), m_gen % 16);
      chk("cyc_go4",     int'(bus4.o_go),      int'(m_fl == 1));
    end
  end

  task automatic pulse(input int which);
    case (which)
      0: bus.i_run = 1'b1;
      1: bus.i_pause = 1'b1;
      2: bus.i_step = 1'b1;
      default: begin bus.i_run = 1'b1; bus.i_pause = 1'b1; end
    endcase
    @(negedge clk);
    bus.i_run = 1'b0; bus.i_pause = 1'b0; bus.i_step = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (bus.o_busy && n < max) begin @(negedge clk); n++; end
    chk("wait_idle", int'(bus.o_busy), 0);
  endtask

  task automatic wait_go(input int max, output int n);
    n = 0;
    while (!bus.o_go && n < max) begin @(negedge clk); n++; end
    chk("wait_go", int'(bus.o_go), 1);
  endtask

  task automatic count_go(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin @(negedge clk); cnt += int'(bus.o_go); end
  endtask

  task automatic do_step();
    pulse(2);
    wait_idle(40);
  endtask

  int n;

  initial begin
    bus.i_run = 0; bus.i_pause = 0; bus.i_step = 0; bus.i_speed = '0; bus.i_edit_req = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_go",      int'(bus.o_go), 0);
    chk("rst_gnt",     int'(bus.o_edit_gnt), 0);
    chk("rst_running", int'(bus.o_running), 0);
    chk("rst_busy",    int'(bus.o_busy), 0);
    chk("rst_gen",     int'(bus.o_gen_cnt), 0);
    repeat (3) @(negedge clk);

    // single step
    chk("t1_go_before", int'(bus.o_go), 0);
    pulse(2);
    chk("t1_go", int'(bus.o_go), 1);
    @(negedge clk);
    chk("t1_go_width", int'(bus.o_go), 0);
    chk("t1_busy", int'(bus.o_busy), 1);
    wait_idle(30);
    chk("t1_gen", int'(bus.o_gen_cnt), 1);
    chk("t1_running", int'(bus.o_running), 0);
    count_go(30, n);
    chk("t1_no_rego", n, 0);

    // free run at speed 2, then pause inside the fifth sweep
    bus.i_speed = 3'd2;
    pulse(0);
    wait_go(100, n);
    chk("t2_first_wait", n, 12);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      wait_go(100, n);
      chk("t2_gap", n + 1, 24);
    end
    chk("t2_gen_at_5th_go", int'(bus.o_gen_cnt), 5);
    repeat (3) @(negedge clk);
    pulse(1);
    chk("t3_running_pend", int'(bus.o_running), 1);
    wait_idle(40);
    chk("t3_gen", int'(bus.o_gen_cnt), 6);
    chk("t3_running", int'(bus.o_running), 0);
    count_go(200, n);
    chk("t3_no_go", n, 0);

    // run and pause together, then step while running
    pulse(3);
    chk("t5_both_running", int'(bus.o_running), 0);
    chk("t5_both_busy", int'(bus.o_busy), 0);
    count_go(20, n);
    chk("t5_both_no_go", n, 0);
    bus.i_speed = 3'd0;
    pulse(0);
    pulse(2);
    chk("t5_step_no_go", int'(bus.o_go), 0);
    wait_go(20, n);
    chk("t5_step_latency", n, 3);
    repeat (2) @(negedge clk);
    pulse(1);
    wait_idle(40);
    chk("t5_gen", int'(bus.o_gen_cnt), 7);
    chk("t5_running", int'(bus.o_running), 0);

    // edit arbitration
    bus.i_speed = 3'd2;
    pulse(0);
    wait_go(100, n);
    chk("t4_first_wait", n, 12);
    repeat (2) @(negedge clk);
    bus.i_edit_req = 1'b1;
    @(negedge clk);
    chk("t4_gnt_in_sim", int'(bus.o_edit_gnt), 0);
    wait_idle(40);
    chk("t4_gnt_at_exit", int'(bus.o_edit_gnt), 0);
    @(negedge clk);
    chk("t4_gnt", int'(bus.o_edit_gnt), 1);
    chk("t4_running", int'(bus.o_running), 1);
    count_go(40, n);
    chk("t4_no_go_held", n, 0);
    chk("t4_gnt_held", int'(bus.o_edit_gnt), 1);
    bus.i_edit_req = 1'b0;
    wait_go(100, n);
    chk("t4_release_wait", n, 13);
    wait_idle(40);
    chk("t4_gen", int'(bus.o_gen_cnt), 9);
    repeat (5) @(negedge clk);
    bus.i_edit_req = 1'b1;
    count_go(20, n);
    chk("t4_mid_no_go", n, 0);
    bus.i_edit_req = 1'b0;
    wait_go(100, n);
    chk("t4_resume_wait", n, 8);
    repeat (2) @(negedge clk);
    pulse(1);
    wait_idle(40);
    chk("t4_gen_end", int'(bus.o_gen_cnt), 10);

    // async reset while waiting with gen_cnt = 7
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) do_step();
    chk("t6_gen7", int'(bus.o_gen_cnt), 7);
    bus.i_speed = 3'd3;
    pulse(0);
    repeat (4) @(negedge clk);
    chk("t6_running_pre", int'(bus.o_running), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_go",      int'(bus.o_go), 0);
    chk("t6_gnt",     int'(bus.o_edit_gnt), 0);
    chk("t6_running", int'(bus.o_running), 0);
    chk("t6_busy",    int'(bus.o_busy), 0);
    chk("t6_gen",     int'(bus.o_gen_cnt), 0);
    chk("t6_gen4",    int'(bus4.o_gen_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_speed = 3'd0;
    @(negedge clk);

    // generation counter wrap on the 4-bit instance
    repeat (16) do_step();
    chk("t7_gen16", int'(bus.o_gen_cnt), 16);
    chk("t7_gen4_wrap", int'(bus4.o_gen_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
